framebuffer_to_vga: RTL and testbench
=====================================

# framebuffer_to_vga

Reader side of the frame-buffer RAM. It generates 640x480@60 VGA timing from the 25 MHz pixel clock and fetches pixels from the RAM filled by the ROM-to-RAM upscaler. The image is 160x120 native or 320x240 upscaled, selected by `switch`, and is drawn centred on a black background. `hsync`, `vsync`, `video_on`, `pixel` and `frame_start` are delivered cycle-aligned.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- LARGURA, 160, native image width; ALTURA, 120, native image height
- FATOR, 2, upscale factor used when switch=1
- RAM_LATENCY, 1, read latency of the RAM in clk cycles; legal values 1 or 2
- OUTLINE_COLOR, 8'hFF, outline colour (used only with FBR_OUTLINE_EN)

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-high
- switch  in  1  0 = native geometry, 1 = upscaled geometry
- fb_ready  in  1  frame buffer is filled (the writer's done)
- ram_rdaddr  out  19  RAM read address
- ram_q  in  8  RAM read data, valid RAM_LATENCY cycles after the address
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high inside the 640x480 active area
- pixel  out  8  pixel colour; 0 when video_on=0
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

## Operation
- Counters:
  - h_cnt runs 0..799 and wraps to 0; v_cnt increments on each h wrap, runs 0..524 and wraps to 0.
  - Reset value of both counters is 0.
- Frame latch: when h_cnt=0 and v_cnt=0, sample `switch` into sw_q and `fb_ready` into act_q. Both hold for the whole frame. Reset value of sw_q and act_q is 0.
- Geometry:
  - img_w = sw_q ? LARGURA*FATOR : LARGURA; img_h = sw_q ? ALTURA*FATOR : ALTURA.
  - x0 = (H_ACTIVE-img_w)/2, y0 = (V_ACTIVE-img_h)/2.
  - Defaults give (240,180) native and (160,120) upscaled.
- Window: in_img = act_q && x0 ≤ h_cnt < x0+img_w && y0 ≤ v_cnt < y0+img_h.
- Address:
  - Inside the window, ram_rdaddr = (v_cnt−y0)*img_w + (h_cnt−x0), computed in 19 bits with no overflow; the maximum is 76799.
  - Outside the window, ram_rdaddr = 0.
  - The implementation may compute the address incrementally, but the values must be identical to the formula.
- Pixel select: pixel = in_img ? ram_q : 0x00 (or outline, see Configuration). ram_q is ignored outside the window.
- Sync:
  - hsync = 0 for h_cnt in [656,751]; vsync = 0 for v_cnt in [490,491].
  - video_on = (h_cnt<640 && v_cnt<480).
- Not ready: act_q=0 gives black for the entire frame. A rise of fb_ready mid-frame takes effect only at the next (0,0).

## Timing
- Pipeline:
  - Stage 0: counters.
  - Stage 1: ram_rdaddr and the in_img/sync flags are registered.
  - ram_q arrives after stage 1 + RAM_LATENCY.
  - Output stage: pixel is registered.
- Total latency from counter value to outputs is 2+RAM_LATENCY cycles (3 by default). hsync, vsync, video_on and frame_start are delayed by exactly that amount through a shift register.
- Reset values (asynchronous, immediate):
  - hsync=1, vsync=1, video_on=0, pixel=0, frame_start=0, ram_rdaddr=0.
  - All delay stages are cleared.
- Reset mid-frame: outputs go to their reset values at once. After release, the counters restart at (0,0), and frame_start pulses 2+RAM_LATENCY cycles after the first edge.
- A toggle of `switch` or `fb_ready` mid-frame has no effect before the next frame latch.

## Configuration
- FBR_OUTLINE_EN defined:
  - Pixels on the 1-pixel ring just outside the window output OUTLINE_COLOR when act_q=1.
  - The ring is h in {x0−1, x0+img_w} with y0−1 ≤ v ≤ y0+img_h, and v in {y0−1, y0+img_h} with x0−1 ≤ h ≤ x0+img_w.
  - ram_rdaddr on the ring is 0.
- FBR_OUTLINE_EN undefined: the ring is black (0x00); OUTLINE_COLOR is unused.

## Structure
- Shared package fb_pkg holds:
  - VGA timing constants and H_TOTAL=800, V_TOTAL=525;
  - FB_ADDR_W=19 and PIX_W=8;
  - BG_COLOR=8'h00.
- Sub-module vga_timing_gen (h_cnt/v_cnt counters, raw sync and video_on). The top level adds the frame latch, address generator and alignment pipeline.

## Test plan
- Reset release, fb_ready=1, switch=0 → line period 800 clk and frame period 420000 clk. hsync low for 96 clk, starting 656+3 clk after a line starts. vsync low for 2 lines.
- switch=0 → addr 0 at counter (240,180) and addr 19199 at (399,299). With RAM model q=addr[7:0], pixel at screen (240,180) is 0x00 and at (241,180) is 0x01. Outside the window, pixel=0.
- switch=1 → window x 160..479, y 120..359; addr 76799 at (479,359); addr 320 at (160,121).
- fb_ready=0 for a full frame → pixel=0 everywhere. Raise fb_ready at v=200 → still black until the next frame_start, then the image appears.
- Toggle switch at v=250 → geometry unchanged until the next frame; the following frame uses the new window.
- Assert reset at v=200 → outputs immediately hsync=1, vsync=1, video_on=0, pixel=0. After release, frame_start pulses at cycle 3. With FBR_OUTLINE_EN and switch=0, pixel (239,180) = 0xFF.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared VGA timing, frame-buffer widths and pipeline control types for the reader
package fb_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 10;

  localparam logic [PIX_W-1:0] BG_COLOR = 8'h00;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [FB_ADDR_W-1:0] addr_t;

  // Per-pixel flags that travel alongside the RAM read
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_start;
    logic in_img;
    logic ring;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

  function automatic logic in_range(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running h/v counters with raw (undelayed) sync, active and frame-start flags
module vga_timing_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             video_on_raw,
  output logic             frame_start_raw
);

  localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt           = h_cnt_q;
  assign v_cnt           = v_cnt_q;
  assign hsync_raw       = !in_range(h_cnt_q, HS_FIRST, HS_LAST);
  assign vsync_raw       = !in_range(v_cnt_q, VS_FIRST, VS_LAST);
  assign video_on_raw    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_start_raw = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/framebuffer_to_vga.sv
// rtl/framebuffer_to_vga.sv - frame-buffer reader: centred image window, RAM address and aligned VGA outputs (FBR_OUTLINE_EN adds a 1-pixel outline)
module framebuffer_to_vga
  import fb_pkg::*;
#(
  parameter int               H_ACTIVE      = VGA_H_ACTIVE,
  parameter int               H_FP          = VGA_H_FP,
  parameter int               H_SYNC        = VGA_H_SYNC,
  parameter int               H_BP          = VGA_H_BP,
  parameter int               V_ACTIVE      = VGA_V_ACTIVE,
  parameter int               V_FP          = VGA_V_FP,
  parameter int               V_SYNC        = VGA_V_SYNC,
  parameter int               V_BP          = VGA_V_BP,
  parameter int               LARGURA       = 160,
  parameter int               ALTURA        = 120,
  parameter int               FATOR         = 2,
  parameter int               RAM_LATENCY   = 1,
  parameter logic [PIX_W-1:0] OUTLINE_COLOR = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 switch,
  input  logic                 fb_ready,
  output logic [FB_ADDR_W-1:0] ram_rdaddr,
  input  logic [PIX_W-1:0]     ram_q,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [PIX_W-1:0]     pixel,
  output logic                 frame_start
);

  localparam cnt_t IMG_W_N = cnt_t'(LARGURA);
  localparam cnt_t IMG_W_U = cnt_t'(LARGURA * FATOR);
  localparam cnt_t IMG_H_N = cnt_t'(ALTURA);
  localparam cnt_t IMG_H_U = cnt_t'(ALTURA * FATOR);
  localparam cnt_t X0_N    = cnt_t'((H_ACTIVE - LARGURA) / 2);
  localparam cnt_t X0_U    = cnt_t'((H_ACTIVE - LARGURA * FATOR) / 2);
  localparam cnt_t Y0_N    = cnt_t'((V_ACTIVE - ALTURA) / 2);
  localparam cnt_t Y0_U    = cnt_t'((V_ACTIVE - ALTURA * FATOR) / 2);

  cnt_t h_cnt, v_cnt;
  logic hsync_raw, vsync_raw, video_on_raw, frame_start_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk             (clk),
    .reset           (reset),
    .h_cnt           (h_cnt),
    .v_cnt           (v_cnt),
    .hsync_raw       (hsync_raw),
    .vsync_raw       (vsync_raw),
    .video_on_raw    (video_on_raw),
    .frame_start_raw (frame_start_raw)
  );

  logic sw_q, sw_d;
  logic act_q, act_d;
  cnt_t img_w, img_h, x0, y0, x_end, y_end;
  logic in_win, on_ring;
  addr_t addr_q, addr_d;
  ctrl_t s1_q, s1_d;
  ctrl_t dly_q [RAM_LATENCY];
  ctrl_t dly_d [RAM_LATENCY];
  ctrl_t last;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  // Geometry and readiness are frozen at (0,0) so a frame is never drawn half-and-half
  always_comb begin
    sw_d  = sw_q;
    act_d = act_q;
    if ((h_cnt == '0) && (v_cnt == '0)) begin
      sw_d  = switch;
      act_d = fb_ready;
    end
  end

  always_comb begin
    img_w  = sw_q ? IMG_W_U : IMG_W_N;
    img_h  = sw_q ? IMG_H_U : IMG_H_N;
    x0     = sw_q ? X0_U : X0_N;
    y0     = sw_q ? Y0_U : Y0_N;
    x_end  = x0 + img_w;
    y_end  = y0 + img_h;
    in_win = act_q && (h_cnt >= x0) && (h_cnt < x_end) && (v_cnt >= y0) && (v_cnt < y_end);
`ifdef FBR_OUTLINE_EN
    on_ring = act_q && !in_win
              && in_range(h_cnt, x0 - cnt_t'(1), x_end)
              && in_range(v_cnt, y0 - cnt_t'(1), y_end);
`else
    on_ring = 1'b0;
`endif
    addr_d = '0;
    if (in_win) begin
      addr_d = addr_t'(v_cnt - y0) * addr_t'(img_w) + addr_t'(h_cnt - x0);
    end
    s1_d = '{hsync: hsync_raw, vsync: vsync_raw, video_on: video_on_raw,
             frame_start: frame_start_raw, in_img: in_win, ring: on_ring};
  end

  // Flags wait out the RAM read so they line up with ram_q
  always_comb begin
    dly_d[0] = s1_q;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_comb begin
    last          = dly_q[RAM_LATENCY-1];
    hsync_d       = last.hsync;
    vsync_d       = last.vsync;
    video_on_d    = last.video_on;
    frame_start_d = last.frame_start;
    pixel_d       = last.in_img ? ram_q : (last.ring ? OUTLINE_COLOR : BG_COLOR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_q          <= 1'b0;
      act_q         <= 1'b0;
      addr_q        <= '0;
      s1_q          <= CTRL_IDLE;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        dly_q[i] <= CTRL_IDLE;
      end
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_q       <= '0;
    end else begin
      sw_q          <= sw_d;
      act_q         <= act_d;
      addr_q        <= addr_d;
      s1_q          <= s1_d;
      dly_q         <= dly_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      pixel_q       <= pixel_d;
    end
  end

  assign ram_rdaddr  = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign pixel       = pixel_q;

endmodule

// File: tb/tb_framebuffer_to_vga.sv
// tb/tb_framebuffer_to_vga.sv - scoreboard bench: scaled-timing instance fully modelled, default instance checked over its first lines
module tb_framebuffer_to_vga;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
  localparam int LW = 16, LH = 12, F = 2;
  localparam int H_TOT = HA + HFP + HS + HBP;
  localparam int V_TOT = VA + VFP + VS + VBP;
  localparam int FRAME = H_TOT * V_TOT;
`ifdef FBR_OUTLINE_EN
  localparam bit OUTLINE = 1'b1;
`else
  localparam bit OUTLINE = 1'b0;
`endif

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] out;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, switch, fb_ready;
  logic [18:0] ram_rdaddr, ram_rdaddr0;
  logic [7:0]  ram_q = 8'h00, ram_q0 = 8'h00;
  logic        hsync, vsync, video_on, frame_start;
  logic        hsync0, vsync0, video_on0, frame_start0;
  logic [7:0]  pixel, pixel0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  framebuffer_to_vga #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .LARGURA(LW), .ALTURA(LH), .FATOR(F), .RAM_LATENCY(1), .OUTLINE_COLOR(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .switch(switch), .fb_ready(fb_ready),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel(pixel), .frame_start(frame_start)
  );

  framebuffer_to_vga dut0 (
    .clk(clk), .reset(reset), .switch(switch), .fb_ready(fb_ready),
    .ram_rdaddr(ram_rdaddr0), .ram_q(ram_q0), .hsync(hsync0), .vsync(vsync0),
    .video_on(video_on0), .pixel(pixel0), .frame_start(frame_start0)
  );

  // RAM model: one-cycle read latency, content = low address byte
  always @(posedge clk) begin
    ram_q  <= ram_rdaddr[7:0];
    ram_q0 <= ram_rdaddr0[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int h, input int v, input bit sw, input bit act);
    int w, hh, x0, y0, a;
    bit inw, ring;
    logic [7:0] pix;
    exp_t e;
    w    = sw ? LW * F : LW;
    hh   = sw ? LH * F : LH;
    x0   = (HA - w) / 2;
    y0   = (VA - hh) / 2;
    inw  = act && h >= x0 && h < x0 + w && v >= y0 && v < y0 + hh;
    ring = OUTLINE && act && !inw && h >= x0 - 1 && h <= x0 + w && v >= y0 - 1 && v <= y0 + hh;
    a    = inw ? (v - y0) * w + (h - x0) : 0;
    pix  = inw ? 8'(a) : (ring ? 8'hFF : 8'h00);
    e.addr = 19'(a);
    e.out  = {!(h >= HA + HFP && h < HA + HFP + HS), !(v >= VA + VFP && v < VA + VFP + VS),
              (h < HA && v < VA), (h == 0 && v == 0), pix};
    return e;
  endfunction

  localparam exp_t IDLE = '{addr: 19'd0, out: {1'b1, 1'b1, 1'b0, 1'b0, 8'h00}};

  int   mh, mv;
  bit   sw_m, act_m;
  exp_t sb[$];

  // Scoreboard: expectation for the current counter value is pushed, the one from 3 cycles ago is compared
  always @(negedge clk) begin
    exp_t e, p;
    if (reset) begin
      mh = 0; mv = 0; sw_m = 1'b0; act_m = 1'b0;
      sb.delete();
      repeat (3) sb.push_back(IDLE);
    end else begin
      e = model(mh, mv, sw_m, act_m);
      sb.push_back(e);
      check("addr", 32'(ram_rdaddr), 32'(sb[sb.size()-2].addr));
      p = sb.pop_front();
      check("out", 32'({hsync, vsync, video_on, frame_start, pixel}), 32'(p.out));
      if (mh == 0 && mv == 0) begin
        sw_m  = switch;
        act_m = fb_ready;
      end
      mh = mh + 1;
      if (mh == H_TOT) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end
    end
  end

  // Default-geometry instance over its first two lines
  int n0;
  always @(negedge clk) begin
    int hd;
    logic [30:0] x;
    if (reset) begin
      n0 = 0;
    end else if (n0 < 1700) begin
      if (n0 < 3) begin
        x = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 19'd0};
      end else begin
        hd = (n0 - 3) % 800;
        x  = {!(hd >= 656 && hd <= 751), 1'b1, (hd < 640), (n0 == 3), 8'h00, 19'd0};
      end
      check("dflt", 32'({hsync0, vsync0, video_on0, frame_start0, pixel0, ram_rdaddr0}), 32'(x));
      n0++;
    end
  end

  int  cyc = 0;
  int  hs_fall = -1, vs_fall = -1, fs_last = -1;
  int  hs_period = 0, hs_low = 0, hs_phase = 0, vs_low = 0, fs_period = 0;
  bit  prev_hs = 1'b1, prev_vs = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_hs && !hsync) begin
        if (hs_fall >= 0) hs_period = cyc - hs_fall;
        hs_fall  = cyc;
        hs_phase = (cyc - fs_last) % H_TOT;
      end
      if (!prev_hs && hsync && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (prev_vs && !vsync) vs_fall = cyc;
      if (!prev_vs && vsync && vs_fall >= 0) vs_low = cyc - vs_fall;
      if (frame_start) begin
        if (fs_last >= 0) fs_period = cyc - fs_last;
        fs_last = cyc;
      end
    end
    prev_hs = hsync;
    prev_vs = vsync;
  end

  task automatic check_reset_outputs();
    check("rst_hs", 32'(hsync), 32'd1);
    check("rst_vs", 32'(vsync), 32'd1);
    check("rst_von", 32'(video_on), 32'd0);
    check("rst_pix", 32'(pixel), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_addr", 32'(ram_rdaddr), 32'd0);
  endtask

  task automatic release_reset();
    int lat = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (frame_start && lat == 0) lat = k;
    end
    check("fs_lat", 32'(lat), 32'd3);
  endtask

  task automatic wait_v(input int t);
    int n = 0;
    while (mv != t && n < 2 * FRAME) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("wait_v", 32'(mv), 32'(t));
  endtask

  initial begin
    reset = 1'b1; switch = 1'b0; fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    release_reset();
    repeat (2 * FRAME + 100) @(posedge clk);
    check("hs_period", 32'(hs_period), 32'(H_TOT));
    check("hs_low", 32'(hs_low), 32'(HS));
    check("hs_phase", 32'(hs_phase), 32'(HA + HFP));
    check("vs_low", 32'(vs_low), 32'(VS * H_TOT));
    check("fs_period", 32'(fs_period), 32'(FRAME));

    wait_v(25); switch = 1'b1;
    repeat (2 * FRAME) @(posedge clk);

    wait_v(25); fb_ready = 1'b0;
    wait_v(0);
    wait_v(20); fb_ready = 1'b1;
    repeat (2 * FRAME) @(posedge clk);

    wait_v(25); switch = 1'b0;
    repeat (2 * FRAME) @(posedge clk);

    wait_v(20);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    release_reset();
    repeat (FRAME + 200) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
